// File: rtl/friscv_pmp_encoder.sv
// Converts a naturally aligned {base, log2 size} region into a pmpaddr/pmpcfg pair (NA4 or NAPOT).
// Latency: 1 cycle for NA4 or errors, k-2 cycles for NAPOT; result held until rsp_ready.
module friscv_pmp_encoder #(
   parameter int XLEN = 32,
   parameter int RLEN = XLEN + 2
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [RLEN-1:0] req_base,
   input  logic [5:0]      req_size,
   input  logic [2:0]      req_perm,
   input  logic            req_lock,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_pmpaddr,
   output logic [7:0]      rsp_pmpcfg,
   output logic            rsp_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENCODE,
      S_RESP
   } state_e;

   state_e          state_q, state_d;
   logic [RLEN-1:0] base_q, base_d;
   logic [5:0]      size_q, size_d;
   logic [2:0]      perm_q, perm_d;
   logic            lock_q, lock_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] pmpaddr_q, pmpaddr_d;
   logic [7:0]      pmpcfg_q, pmpcfg_d;
   logic            error_q, error_d;

   logic [RLEN-1:0] low_mask;
   logic            bad;

   // Shift saturates to all-ones mask when k >= RLEN; k > RLEN is rejected anyway.
   assign low_mask = ~({RLEN{1'b1}} << size_q);
   assign bad      = (size_q < 6'd2) || (size_q > 6'(RLEN)) || ((base_q & low_mask) != '0);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      size_d    = size_q;
      perm_d    = perm_q;
      lock_d    = lock_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      pmpaddr_d = pmpaddr_q;
      pmpcfg_d  = pmpcfg_q;
      error_d   = error_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               base_d  = req_base;
               size_d  = req_size;
               perm_d  = req_perm;
               lock_d  = req_lock;
               addr_d  = req_base[RLEN-1:2];
               cnt_d   = 6'd0;
               state_d = S_ENCODE;
            end
         end
         S_ENCODE: begin
            if (bad) begin
               pmpaddr_d = '0;
               pmpcfg_d  = 8'h00;
               error_d   = 1'b1;
               state_d   = S_RESP;
            end else if (size_q == 6'd2) begin
               pmpaddr_d = addr_q;
               pmpcfg_d  = {lock_q, 2'b00, 2'b10, perm_q};
               error_d   = 1'b0;
               state_d   = S_RESP;
            end else if (cnt_q < size_q - 6'd3) begin
               // One trailing-ones bit per cycle; bit k-3 stays 0 due to alignment.
               addr_d = addr_q | (XLEN'(1) << cnt_q);
               cnt_d  = cnt_q + 6'd1;
            end else begin
               pmpaddr_d = addr_q;
               pmpcfg_d  = {lock_q, 2'b00, 2'b11, perm_q};
               error_d   = 1'b0;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         size_q    <= 6'd0;
         perm_q    <= 3'd0;
         lock_q    <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= 6'd0;
         pmpaddr_q <= '0;
         pmpcfg_q  <= 8'h00;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         size_q    <= size_d;
         perm_q    <= perm_d;
         lock_q    <= lock_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         pmpaddr_q <= pmpaddr_d;
         pmpcfg_q  <= pmpcfg_d;
         error_q   <= error_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_pmpaddr = pmpaddr_q;
   assign rsp_pmpcfg  = pmpcfg_q;
   assign rsp_error   = error_q;

endmodule

// File: tb/tb_friscv_pmp_encoder.sv
// Directed vector bench for friscv_pmp_encoder: table of region requests plus backpressure and reset corner cases.
module tb_friscv_pmp_encoder;

   localparam int XLEN = 32;
   localparam int RLEN = 34;

   logic            aclk;
   logic            aresetn;
   logic            req_valid;
   logic            req_ready;
   logic [RLEN-1:0] req_base;
   logic [5:0]      req_size;
   logic [2:0]      req_perm;
   logic            req_lock;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_pmpaddr;
   logic [7:0]      rsp_pmpcfg;
   logic            rsp_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [RLEN-1:0] base;
      logic [5:0]      size;
      logic [2:0]      perm;
      logic            lock;
      logic [XLEN-1:0] exp_addr;
      logic [7:0]      exp_cfg;
      logic            exp_err;
      int              exp_lat;
   } vec_t;

   vec_t vecs[12];

   friscv_pmp_encoder #(.XLEN(XLEN), .RLEN(RLEN)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_base    (req_base),
      .req_size    (req_size),
      .req_perm    (req_perm),
      .req_lock    (req_lock),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_pmpaddr (rsp_pmpaddr),
      .rsp_pmpcfg  (rsp_pmpcfg),
      .rsp_error   (rsp_error)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Returns edges from accept to rsp_valid (0 if never seen within budget).
   task automatic wait_rsp(output int lat);
      int i;
      lat = 0;
      i = 0;
      while (lat == 0 && i < 64) begin
         i++;
         @(posedge aclk); #1;
         if (rsp_valid) lat = i;
      end
   endtask

   task automatic do_req(input vec_t v, input int idx);
      int lat;
      string tag;
      tag = $sformatf("vec%0d", idx);
      check({tag, " req_ready_idle"}, 64'(req_ready), 64'd1);
      req_base  = v.base;
      req_size  = v.size;
      req_perm  = v.perm;
      req_lock  = v.lock;
      req_valid = 1'b1;
      @(posedge aclk); #1;
      req_valid = 1'b0;
      req_base  = '1;
      req_size  = 6'h3F;
      wait_rsp(lat);
      check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
      check({tag, " pmpaddr"}, 64'(rsp_pmpaddr), 64'(v.exp_addr));
      check({tag, " pmpcfg"}, 64'(rsp_pmpcfg), 64'(v.exp_cfg));
      check({tag, " error"}, 64'(rsp_error), 64'(v.exp_err));
      rsp_ready = 1'b1;
      @(posedge aclk); #1;
      rsp_ready = 1'b0;
      check({tag, " rsp_valid_after_hs"}, 64'(rsp_valid), 64'd0);
      check({tag, " req_ready_after_hs"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      int lat;
      int seen;
      vec_t v;

      vecs[0]  = '{34'h0_0000_1000, 6'd2,  3'b011, 1'b0, 32'h0000_0400, 8'h13, 1'b0, 1};
      vecs[1]  = '{34'h0_0000_2000, 6'd12, 3'b101, 1'b1, 32'h0000_09FF, 8'h9D, 1'b0, 10};
      vecs[2]  = '{34'h0_0000_1004, 6'd4,  3'b111, 1'b1, 32'h0000_0000, 8'h00, 1'b1, 1};
      vecs[3]  = '{34'h0_0000_0000, 6'd1,  3'b111, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1};
      vecs[4]  = '{34'h0_0000_0000, 6'd35, 3'b111, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1};
      vecs[5]  = '{34'h0_0000_0000, 6'd34, 3'b111, 1'b0, 32'h7FFF_FFFF, 8'h1F, 1'b0, 32};
      vecs[6]  = '{34'h0_0000_0008, 6'd3,  3'b001, 1'b0, 32'h0000_0002, 8'h19, 1'b0, 1};
      vecs[7]  = '{34'h0_0000_0000, 6'd0,  3'b001, 1'b1, 32'h0000_0000, 8'h00, 1'b1, 1};
      vecs[8]  = '{34'h3_0000_000C, 6'd2,  3'b100, 1'b1, 32'hC000_0003, 8'h94, 1'b0, 1};
      vecs[9]  = '{34'h2_0000_0000, 6'd33, 3'b010, 1'b0, 32'hBFFF_FFFF, 8'h1A, 1'b0, 31};
      vecs[10] = '{34'h2_0000_0000, 6'd34, 3'b010, 1'b0, 32'h0000_0000, 8'h00, 1'b1, 1};
      vecs[11] = '{34'h1_2345_0000, 6'd16, 3'b011, 1'b1, 32'h48D1_5FFF, 8'h9B, 1'b0, 14};

      aresetn   = 1'b0;
      req_valid = 1'b0;
      req_base  = '0;
      req_size  = 6'd0;
      req_perm  = 3'd0;
      req_lock  = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset pmpaddr", 64'(rsp_pmpaddr), 64'd0);
      check("reset pmpcfg", 64'(rsp_pmpcfg), 64'd0);
      check("reset error", 64'(rsp_error), 64'd0);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      for (int i = 0; i < 12; i++) begin
         do_req(vecs[i], i);
      end

      // Backpressure: hold response while a second request waits on req_valid.
      req_base  = 34'h0_0000_0010;
      req_size  = 6'd4;
      req_perm  = 3'b001;
      req_lock  = 1'b0;
      req_valid = 1'b1;
      @(posedge aclk); #1;
      req_base  = 34'h0_0000_1000;
      req_size  = 6'd2;
      req_perm  = 3'b011;
      req_lock  = 1'b0;
      wait_rsp(lat);
      check("bp latency", 64'(lat), 64'd2);
      for (int i = 0; i < 5; i++) begin
         check("bp rsp_valid", 64'(rsp_valid), 64'd1);
         check("bp req_ready", 64'(req_ready), 64'd0);
         check("bp pmpaddr", 64'(rsp_pmpaddr), 64'h5);
         check("bp pmpcfg", 64'(rsp_pmpcfg), 64'h19);
         check("bp error", 64'(rsp_error), 64'd0);
         @(posedge aclk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge aclk); #1;
      rsp_ready = 1'b0;
      check("bp hs rsp_valid", 64'(rsp_valid), 64'd0);
      check("bp hs req_ready", 64'(req_ready), 64'd1);
      @(posedge aclk); #1;
      req_valid = 1'b0;
      check("bp second accepted", 64'(req_ready), 64'd0);
      wait_rsp(lat);
      check("bp second latency", 64'(lat), 64'd1);
      check("bp second pmpaddr", 64'(rsp_pmpaddr), 64'h400);
      check("bp second pmpcfg", 64'(rsp_pmpcfg), 64'h13);
      rsp_ready = 1'b1;
      @(posedge aclk); #1;
      rsp_ready = 1'b0;

      // Reset during a long NAPOT encode must drop the request entirely.
      req_base  = 34'h0_0010_0000;
      req_size  = 6'd20;
      req_perm  = 3'b111;
      req_lock  = 1'b1;
      req_valid = 1'b1;
      @(posedge aclk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge aclk);
      #1;
      check("mid reset busy", 64'(req_ready), 64'd0);
      aresetn = 1'b0;
      #1;
      check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid reset req_ready", 64'(req_ready), 64'd1);
      check("mid reset pmpaddr", 64'(rsp_pmpaddr), 64'd0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge aclk); #1;
         if (rsp_valid || !req_ready) seen++;
      end
      check("post reset quiet", 64'(seen), 64'd0);
      v = vecs[0];
      do_req(v, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
